// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module : rf_pkg
// Brief  : Shared encodings and default widths for the register-file write
//          port arbiter (state encoding, requester IDs, bus widths).
// Rev    : 1.0  initial release
// ============================================================================
package rf_pkg;

  // Default register-file geometry
  localparam int RF_ADDR_W = 3;
  localparam int RF_BUS_W  = 8;

  // Controller state encoding
  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_ARB   = 1'b1;

  // Requester identifiers (also the value reported on last_grant)
  localparam logic REQ_ALU  = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

  typedef enum logic {
    S_CLEAR = ST_CLEAR,
    S_ARB   = ST_ARB
  } state_e;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter2
// Brief  : Two-way round-robin arbiter. A lone valid requester always wins;
//          when both are valid the pointer picks the winner, and every grant
//          moves the pointer to the other requester.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic ptr_q;
  logic ptr_d;

  // Grant decision: disabled -> none, single valid -> it, both -> pointer
  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // Pointer next state: after a grant the other requester is preferred
  always_comb begin
    ptr_d = ptr_q;
    if (|grant) begin
      ptr_d = ~grant[1];
    end
  end

  // Pointer register, requester 0 preferred out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rf_write_arbiter
// Brief  : Shares the register file's single write port between the ALU
//          writeback (req0) and the load unit (req1) with round-robin
//          valid/ready arbitration; the winning write is registered onto
//          the write port one cycle after acceptance.
//          Optional macro RF_ARB_INIT_CLEAR_EN: after every reset, sweep
//          all registers to zero before any request is granted.
// Rev    : 1.0  initial release
// ============================================================================
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int ADDRESS_WIDTH = RF_ADDR_W,
  parameter int BUS_WIDTH     = RF_BUS_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hold,
  input  logic                     req0_valid,
  input  logic [ADDRESS_WIDTH-1:0] req0_addr,
  input  logic [BUS_WIDTH-1:0]     req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [ADDRESS_WIDTH-1:0] req1_addr,
  input  logic [BUS_WIDTH-1:0]     req1_data,
  output logic                     req1_ready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [BUS_WIDTH-1:0]     wr_data,
  output logic                     init_done,
  output logic                     last_grant
);

  localparam int NUM_REG = 1 << ADDRESS_WIDTH;

  logic                     arb_active;
  logic [1:0]               grant;
  logic                     xfer;
  logic                     winner;

  logic                     wr_en_q,      wr_en_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q,    wr_addr_d;
  logic [BUS_WIDTH-1:0]     wr_data_q,    wr_data_d;
  logic                     last_grant_q, last_grant_d;

`ifdef RF_ARB_INIT_CLEAR_EN
  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

  // Sweep sequencing: step through every address, then hand over to ARB
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == S_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == ADDRESS_WIDTH'(NUM_REG - 1)) begin
        state_d = S_ARB;
      end
    end
  end

  // State and clear counter registers; every reset restarts the sweep
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign arb_active = (state_q == S_ARB);
`else
  assign arb_active = 1'b1;
`endif

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_active & ~hold),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  // A grant only ever goes to a valid requester, so any grant is a transfer
  assign xfer       = |grant;
  assign winner     = grant[REQ_LOAD] ? REQ_LOAD : REQ_ALU;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign init_done  = arb_active;

  // Write-port next state: accepted request, sweep write, or idle (hold data)
  always_comb begin
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      wr_en_d      = 1'b1;
      wr_addr_d    = (winner == REQ_LOAD) ? req1_addr : req0_addr;
      wr_data_d    = (winner == REQ_LOAD) ? req1_data : req0_data;
      last_grant_d = winner;
    end
`ifdef RF_ARB_INIT_CLEAR_EN
    if (state_q == S_CLEAR) begin
      wr_en_d   = 1'b1;
      wr_addr_d = clr_cnt_q;
      wr_data_d = '0;
    end
`endif
  end

  // Registered write port and grant history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      last_grant_q <= 1'b0;
    end else begin
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign last_grant = last_grant_q;

endmodule : rf_write_arbiter
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_rf_write_arbiter
// Brief  : Randomized scoreboard bench for rf_write_arbiter. The driver keeps
//          a requester-level model (pending writes, preferred requester) and
//          queues each expected register-file write; a monitor pops the queue
//          at every clock and compares the write port.
//          Honours RF_ARB_INIT_CLEAR_EN for the post-reset sweep.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rf_write_arbiter;

  localparam int AW   = 3;
  localparam int DW   = 8;
  localparam int NREG = 1 << AW;
`ifdef RF_ARB_INIT_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          hold = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          init_done;
  logic          last_grant;

  always #5 clk = ~clk;

  rf_write_arbiter #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .init_done  (init_done),
    .last_grant (last_grant)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          lg;
  } exp_t;

  exp_t q[$];

  // Reference model state
  logic          m_pref;       // requester preferred when both are waiting
  logic          m_lg;
  int            sweep_left;
  logic [AW-1:0] clr;
  logic          pend  [2];
  logic [AW-1:0] paddr [2];
  logic [DW-1:0] pdata [2];
  int            dcount[2];

  // Last write the monitor observed (write port must hold it while idle)
  logic [AW-1:0] seen_addr;
  logic [DW-1:0] seen_data;
  logic          seen_lg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pref     = 1'b0;
    m_lg       = 1'b0;
    sweep_left = CLEAR_EN ? NREG : 0;
    clr        = '0;
    for (int i = 0; i < 2; i++) begin
      pend[i]   = 1'b0;
      dcount[i] = 0;
    end
    seen_addr = '0;
    seen_data = '0;
    seen_lg   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"},      32'(wr_en),      32'(1'b0));
    chk({tag, "_wr_addr"},    32'(wr_addr),    32'(0));
    chk({tag, "_wr_data"},    32'(wr_data),    32'(0));
    chk({tag, "_last_grant"}, 32'(last_grant), 32'(1'b0));
    chk({tag, "_init_done"},  32'(init_done),  32'(!CLEAR_EN));
  endtask

  // Asynchronous reset in the middle of a low clock phase
  task automatic mid_reset();
    #2;
    rst        = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    hold       = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One driver cycle at the falling edge: present requests, predict grant
  task automatic step(input int cyc);
    int  prob;
    int  hprob;
    bit  directed;
    int  g;
    directed = (cyc >= 100 && cyc < 200);
    prob     = directed ? 100 : ((cyc < 100) ? 50 : 40);
    hprob    = (cyc < 100) ? 20 : 30;

    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && ($urandom_range(99) < 32'(prob))) begin
        pend[i] = 1'b1;
        if (directed) begin
          paddr[i] = AW'(i + 1);
          pdata[i] = DW'(((i == 0) ? 8'h10 : 8'h20) + dcount[i]);
          dcount[i]++;
        end else begin
          paddr[i] = AW'($urandom);
          pdata[i] = DW'($urandom);
        end
      end
    end
    req0_valid = pend[0];
    req0_addr  = pend[0] ? paddr[0] : AW'($urandom);
    req0_data  = pend[0] ? pdata[0] : DW'($urandom);
    req1_valid = pend[1];
    req1_addr  = pend[1] ? paddr[1] : AW'($urandom);
    req1_data  = pend[1] ? pdata[1] : DW'($urandom);
    if (directed) hold = (cyc >= 150 && cyc < 153);
    else          hold = ($urandom_range(99) < 32'(hprob));
    #1;

    g = -1;
    if (sweep_left > 0) begin
      chk("init_done_sweep", 32'(init_done), 32'(1'b0));
      q.push_back('{clr, '0, m_lg});
      clr = clr + 1'b1;
      sweep_left--;
    end else begin
      chk("init_done_arb", 32'(init_done), 32'(1'b1));
      if (hold)                   g = -1;
      else if (pend[0] && pend[1]) g = m_pref ? 1 : 0;
      else if (pend[0])           g = 0;
      else if (pend[1])           g = 1;
    end
    chk("req0_ready", 32'(req0_ready), 32'(g == 0));
    chk("req1_ready", 32'(req1_ready), 32'(g == 1));
    if (g >= 0) begin
      q.push_back('{paddr[g], pdata[g], (g == 1)});
      m_pref  = (g == 0);
      m_lg    = (g == 1);
      pend[g] = 1'b0;
    end
  endtask

  // Monitor: every active clock, compare the write port against the queue
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("wr_en_exp1",  32'(wr_en),      32'(1'b1));
          chk("wr_addr",     32'(wr_addr),    32'(e.addr));
          chk("wr_data",     32'(wr_data),    32'(e.data));
          chk("last_grant",  32'(last_grant), 32'(e.lg));
          seen_addr = e.addr;
          seen_data = e.data;
          seen_lg   = e.lg;
        end else begin
          chk("wr_en_exp0",      32'(wr_en),      32'(1'b0));
          chk("wr_addr_hold",    32'(wr_addr),    32'(seen_addr));
          chk("wr_data_hold",    32'(wr_data),    32'(seen_data));
          chk("last_grant_hold", 32'(last_grant), 32'(seen_lg));
        end
      end
    end
  end

  // Main stimulus
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    for (int cyc = 0; cyc < 420; cyc++) begin
      if (cyc == 5 || cyc == 260) mid_reset();
      step(cyc);
      @(negedge clk);
    end
    // Drain: no new requests, every queued write must have appeared
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    hold       = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_rf_write_arbiter
`default_nettype wire
